ucie_ctl_phy_sb_tx_arb: RTL

Sideband TX arbiter in the UCIe PHY. It shares the single sideband message serializer path between two requesters: the adapter configuration path (RDI lp_cfg) and the PHY-internal LTSM message source. Arbitration is per message; once granted, a requester holds the path for all `MSG_FLITS` flits. The block returns one `pl_cfg_crd` pulse to the adapter for every adapter message it forwards, and flags protocol violations.

---
 rtl/ucie_ctl_phy_sb_tx_arb.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ucie_ctl_phy_sb_tx_arb.sv
// Purpose: per-message arbiter that shares the sideband serializer between the adapter cfg path and LTSM (UCIE_SB_LTSM_PRIO_EN = fixed LTSM priority on ties).
// Latency: grant one cycle after a valid is seen in IDLE; flits pass through combinationally; credit pulse one cycle after the last adapter flit.
// Backpressure: i_sb_ready feeds the granted requester's ready directly; a stall freezes the flit counter and keeps the grant.
module ucie_ctl_phy_sb_tx_arb #(
  parameter int NC        = 32,
  parameter int MSG_FLITS = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_adp_valid,
  input  logic [NC-1:0] i_adp_data,
  output logic          o_adp_ready,
  output logic          o_rdi_pl_cfg_crd,
  input  logic          i_ltsm_valid,
  input  logic [NC-1:0] i_ltsm_data,
  output logic          o_ltsm_ready,
  output logic          o_sb_data_valid,
  output logic [NC-1:0] o_data_sent_sb,
  input  logic          i_sb_ready,
  output logic          o_proto_err
);

  localparam int CW = $clog2(MSG_FLITS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MSG_FLITS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_ADP  = 2'd1,
    GNT_LTSM = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] flit_cnt_q, flit_cnt_d;
  logic          last_gnt_q, last_gnt_d;   // 0 = adapter won last, 1 = LTSM won last
  logic          crd_q, crd_d;
  logic          err_q, err_d;
  logic          xfer;
  logic          last_flit;

  assign xfer             = o_sb_data_valid & i_sb_ready;
  assign last_flit        = (flit_cnt_q == LAST_CNT);
  assign o_rdi_pl_cfg_crd = crd_q;
  assign o_proto_err      = err_q;

  // State, counter, round-robin pointer, credit pulse and sticky error registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      flit_cnt_q <= '0;
      last_gnt_q <= 1'b1;
      crd_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      flit_cnt_q <= flit_cnt_d;
      last_gnt_q <= last_gnt_d;
      crd_q      <= crd_d;
      err_q      <= err_d;
    end
  end

  // Next-state: arbitrate only in IDLE, release the grant after the last flit of a message
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_adp_valid && i_ltsm_valid) begin
`ifdef UCIE_SB_LTSM_PRIO_EN
          state_d = GNT_LTSM;
`else
          state_d = last_gnt_q ? GNT_ADP : GNT_LTSM;
`endif
        end else if (i_adp_valid) begin
          state_d = GNT_ADP;
        end else if (i_ltsm_valid) begin
          state_d = GNT_LTSM;
        end
      end
      GNT_ADP, GNT_LTSM: begin
        if (xfer && last_flit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: steer the granted requester onto the serializer, data forced to zero when not valid
  always_comb begin
    o_sb_data_valid = 1'b0;
    o_data_sent_sb  = '0;
    o_adp_ready     = 1'b0;
    o_ltsm_ready    = 1'b0;
    case (state_q)
      GNT_ADP: begin
        o_sb_data_valid = i_adp_valid;
        o_data_sent_sb  = i_adp_valid ? i_adp_data : '0;
        o_adp_ready     = i_sb_ready;
      end
      GNT_LTSM: begin
        o_sb_data_valid = i_ltsm_valid;
        o_data_sent_sb  = i_ltsm_valid ? i_ltsm_data : '0;
        o_ltsm_ready    = i_sb_ready;
      end
      default: ;
    endcase
  end

  // Message bookkeeping: count flits, record the winner, pulse credit, latch mid-message valid drops
  always_comb begin
    flit_cnt_d = flit_cnt_q;
    last_gnt_d = last_gnt_q;
    crd_d      = 1'b0;
    err_d      = err_q;
    if (state_q != IDLE) begin
      // Dropping valid after the first flit is a violation; the grant is kept regardless
      if ((flit_cnt_q != '0) && !o_sb_data_valid) err_d = 1'b1;
      if (xfer) begin
        if (last_flit) begin
          flit_cnt_d = '0;
          last_gnt_d = (state_q == GNT_LTSM);
          crd_d      = (state_q == GNT_ADP);
        end else begin
          flit_cnt_d = flit_cnt_q + CW'(1);
        end
      end
    end
  end

endmodule
